// File: rtl/ttc_pkg.sv
// Shared types and sizing helpers for the truth-table capture block.
package ttc_pkg;

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, REPORT} ttc_state_e;

    localparam int unsigned N_IN_DEFAULT = 4;
    localparam int unsigned TW           = 2 ** N_IN_DEFAULT;

    // Settle counter must still be one bit wide when no settle cycles are requested.
    function automatic int unsigned settle_cnt_width(input int unsigned settle);
        return (settle < 2) ? 1 : $clog2(settle + 1);
    endfunction

endpackage

// File: rtl/dual_rail_drive.sv
// Registered true/complement rail pair; both rails load together so vec_n is always ~vec.
module dual_rail_drive #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] d,
    output logic [W-1:0] vec,
    output logic [W-1:0] vec_n
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vec   <= '0;
            vec_n <= '1;
        end else if (load) begin
            vec   <= d;
            vec_n <= ~d;
        end
    end

endmodule

// File: rtl/truth_table_capture.sv
// Sweeps every input code into a cell under test, captures its truth table and
// compares it against an expected table.
module truth_table_capture
    import ttc_pkg::*;
#(
    parameter int unsigned N_IN          = N_IN_DEFAULT,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic [(2**N_IN)-1:0] expected,
    output logic [N_IN-1:0]      vec,
    output logic [N_IN-1:0]      vec_n,
    output logic                 vec_valid,
    input  logic                 dut_out,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [(2**N_IN)-1:0] mismatch,
    output logic [N_IN-1:0]      first_fail
);

    localparam int unsigned      TBL_W    = 2 ** N_IN;
    localparam int unsigned      CNT_W    = settle_cnt_width(SETTLE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = (SETTLE_CYCLES > 0) ? CNT_W'(SETTLE_CYCLES - 1) : '0;
    localparam logic [N_IN-1:0]  IDX_LAST = N_IN'(TBL_W - 1);
    // With no settle window each code goes straight to its sample cycle.
    localparam ttc_state_e       ST_HOLD  = (SETTLE_CYCLES > 0) ? DRIVE : SAMPLE;

    ttc_state_e       state_q, state_d;
    logic [N_IN-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TBL_W-1:0] exp_q, exp_d;
    logic [TBL_W-1:0] cap_q, cap_d;
    logic [TBL_W-1:0] mm_q, mm_d;
    logic             pass_q, pass_d;
    logic [N_IN-1:0]  ff_q, ff_d;
    logic             adv;
    logic             vec_load;
    logic [N_IN-1:0]  vec_next;

    function automatic logic [N_IN-1:0] first_set(input logic [TBL_W-1:0] m);
        first_set = '0;
        for (int i = TBL_W - 1; i >= 0; i--) begin
            if (m[i]) first_set = N_IN'(i);
        end
    endfunction

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        exp_d   = exp_q;
        cap_d   = cap_q;
        mm_d    = mm_q;
        pass_d  = pass_q;
        ff_d    = ff_q;
        adv     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    state_d = ST_HOLD;
                    idx_d   = '0;
                    cnt_d   = '0;
                    exp_d   = expected;
                    cap_d   = '0;
                    mm_d    = '0;
                    pass_d  = 1'b0;
                    ff_d    = '0;
                end
            end
            DRIVE: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = SAMPLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SAMPLE: begin
                if (abort) begin
                    state_d = IDLE;
                    idx_d   = '0;
                end else begin
                    cap_d[idx_q] = dut_out;
                    if (idx_q == IDX_LAST) begin
                        // Results are registered here so they are valid during REPORT.
                        state_d = REPORT;
                        mm_d    = cap_d ^ exp_q;
                        pass_d  = (cap_d == exp_q);
                        ff_d    = first_set(cap_d ^ exp_q);
                    end else begin
                        state_d = ST_HOLD;
                        idx_d   = idx_q + N_IN'(1);
                        adv     = 1'b1;
                    end
                end
            end
            REPORT: begin
                state_d = IDLE;
                idx_d   = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Rails reload only when the sweep moves to a new code or leaves/enters IDLE.
    assign vec_load = (state_d != state_q) || adv;
    assign vec_next = (state_d == IDLE) ? '0 : idx_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            exp_q   <= '0;
            cap_q   <= '0;
            mm_q    <= '0;
            pass_q  <= 1'b0;
            ff_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            exp_q   <= exp_d;
            cap_q   <= cap_d;
            mm_q    <= mm_d;
            pass_q  <= pass_d;
            ff_q    <= ff_d;
        end
    end

    dual_rail_drive #(
        .W (N_IN)
    ) u_drive (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (vec_load),
        .d     (vec_next),
        .vec   (vec),
        .vec_n (vec_n)
    );

    assign busy       = (state_q != IDLE);
    assign vec_valid  = (state_q != IDLE);
    assign done       = (state_q == REPORT);
    assign pass       = pass_q;
    assign mismatch   = mm_q;
    assign first_fail = ff_q;

endmodule

// File: tb/tb_truth_table_capture.sv
// Directed bench: table-driven sweeps plus abort, reset and settle-length sequences.
module tb_truth_table_capture;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0, start0 = 1'b0, start3 = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] expected = 16'h0000;
    logic [1:0]  mode = 2'd0;
    logic [15:0] tbl = 16'hA5C3;

    logic [3:0]  vec, vec_n, first_fail;
    logic        vec_valid, dut_out, busy, done, pass;
    logic [15:0] mismatch;
    logic [3:0]  vec0, vec_n0, first_fail0;
    logic        vec_valid0, dut_out0, busy0, done0, pass0;
    logic [15:0] mismatch0;
    logic [3:0]  vec3, vec_n3, first_fail3;
    logic        vec_valid3, dut_out3, busy3, done3, pass3;
    logic [15:0] mismatch3;

    int nvec = 0;
    int nerr = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    // Cell model: 0 = ideal lookup, 1 = code 5 inverted, 2 = stuck at 0.
    function automatic logic model(input logic [3:0] v, input logic [1:0] m, input logic [15:0] t);
        case (m)
            2'd1:    return t[v] ^ (v == 4'd5);
            2'd2:    return 1'b0;
            default: return t[v];
        endcase
    endfunction

    assign dut_out  = model(vec, mode, tbl);
    assign dut_out0 = model(vec0, mode, tbl);
    assign dut_out3 = model(vec3, mode, tbl);

    truth_table_capture #(.N_IN(4), .SETTLE_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
        .vec(vec), .vec_n(vec_n), .vec_valid(vec_valid), .dut_out(dut_out), .busy(busy),
        .done(done), .pass(pass), .mismatch(mismatch), .first_fail(first_fail)
    );

    truth_table_capture #(.N_IN(4), .SETTLE_CYCLES(0)) dut_s0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort), .expected(expected),
        .vec(vec0), .vec_n(vec_n0), .vec_valid(vec_valid0), .dut_out(dut_out0), .busy(busy0),
        .done(done0), .pass(pass0), .mismatch(mismatch0), .first_fail(first_fail0)
    );

    truth_table_capture #(.N_IN(4), .SETTLE_CYCLES(3)) dut_s3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .abort(abort), .expected(expected),
        .vec(vec3), .vec_n(vec_n3), .vec_valid(vec_valid3), .dut_out(dut_out3), .busy(busy3),
        .done(done3), .pass(pass3), .mismatch(mismatch3), .first_fail(first_fail3)
    );

    always @(negedge clk) if (done) done_cnt++;

    typedef struct {
        logic [1:0]  mode;
        logic [15:0] exp_tbl;
        logic        pass;
        logic [15:0] mm;
        logic [3:0]  ff;
    } vec_t;

    vec_t vt[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // One full sweep on the SETTLE_CYCLES=2 instance; poke >= 0 pulses start and
    // scrambles expected partway through to show both are ignored mid-sweep.
    task automatic run_sweep(input int i, input int poke);
        int cnt, rail_bad, busy_bad;
        mode     = vt[i].mode;
        expected = vt[i].exp_tbl;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cnt = 0; rail_bad = 0; busy_bad = 0;
        while (!done && cnt < 200) begin
            if (vec_n !== ~vec) rail_bad++;
            if (!busy || !vec_valid) busy_bad++;
            if (cnt == poke) begin
                start    = 1'b1;
                expected = ~vt[i].exp_tbl;
            end
            if (cnt == poke + 1) start = 1'b0;
            @(posedge clk); #1 cnt++;
        end
        chk("latency", cnt, 48);
        chk("rails", rail_bad, 0);
        chk("busy_during_sweep", busy_bad, 0);
        chk("pass", pass, vt[i].pass);
        chk("mismatch", mismatch, vt[i].mm);
        chk("first_fail", first_fail, vt[i].ff);
        chk("vec_in_report", vec, 15);
        @(posedge clk); #1;
        chk("done_pulse_width", done, 0);
        chk("idle_busy_valid", {busy, vec_valid}, 0);
        chk("idle_vec", {vec, vec_n}, 8'h0F);
        chk("held_pass", pass, vt[i].pass);
        chk("held_mismatch", mismatch, vt[i].mm);
        chk("held_first_fail", first_fail, vt[i].ff);
    endtask

    task automatic run_short(input int sel, input int want);
        int cnt, rail_bad, busy_bad;
        mode     = 2'd0;
        expected = 16'hA5C3;
        @(posedge clk); #1;
        if (sel == 0) start0 = 1'b1; else start3 = 1'b1;
        @(posedge clk); #1 start0 = 1'b0; start3 = 1'b0;
        cnt = 0; rail_bad = 0; busy_bad = 0;
        while (!(sel == 0 ? done0 : done3) && cnt < 200) begin
            if (sel == 0 ? (vec_n0 !== ~vec0) : (vec_n3 !== ~vec3)) rail_bad++;
            if (sel == 0 ? !(busy0 && vec_valid0) : !(busy3 && vec_valid3)) busy_bad++;
            @(posedge clk); #1 cnt++;
        end
        chk(sel == 0 ? "latency_s0" : "latency_s3", cnt, want);
        chk("rails_short", rail_bad, 0);
        chk("busy_short", busy_bad, 0);
        chk("pass_short", sel == 0 ? pass0 : pass3, 1);
        chk("mismatch_short", sel == 0 ? mismatch0 : mismatch3, 0);
        chk("first_fail_short", sel == 0 ? first_fail0 : first_fail3, 0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_busy_valid_done"}, {busy, vec_valid, done}, 0);
        chk({tag, "_vec_rails"}, {vec, vec_n}, 8'h0F);
        chk({tag, "_results"}, {pass, mismatch, first_fail}, 0);
    endtask

    initial begin
        int cnt, d0;
        vt[0] = '{2'd0, 16'hA5C3, 1'b1, 16'h0000, 4'd0};
        vt[1] = '{2'd1, 16'hA5C3, 1'b0, 16'h0020, 4'd5};
        vt[2] = '{2'd2, 16'hA5C3, 1'b0, 16'hA5C3, 4'd0};
        vt[3] = '{2'd0, 16'hFFFF, 1'b0, 16'h5A3C, 4'd2};
        vt[4] = '{2'd0, 16'h25C3, 1'b0, 16'h8000, 4'd15};
        vt[5] = '{2'd2, 16'h0000, 1'b1, 16'h0000, 4'd0};

        repeat (3) @(posedge clk);
        #1 chk_reset_outputs("por");
        @(negedge clk) rst_n = 1'b1;

        for (int i = 0; i < 6; i++) run_sweep(i, -1);

        // start and abort together in IDLE: abort wins.
        @(posedge clk); #1 start = 1'b1; abort = 1'b1;
        @(posedge clk); #1 start = 1'b0; abort = 1'b0;
        chk("start_abort_idle", {busy, vec_valid}, 0);

        // Abort while driving code 7.
        d0 = done_cnt; mode = 2'd0; expected = 16'hA5C3;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cnt = 0;
        while (vec != 4'd7 && cnt < 100) begin
            @(posedge clk); #1 cnt++;
        end
        chk("reach_vec7", vec, 7);
        abort = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
        chk_reset_outputs("abort");
        repeat (60) @(posedge clk);
        #1 chk("no_done_after_abort", done_cnt - d0, 0);
        run_sweep(0, -1);

        // start pulse and expected change mid-sweep are ignored.
        d0 = done_cnt;
        run_sweep(0, 10);
        chk("one_done_per_sweep", done_cnt - d0, 1);

        // Asynchronous reset between clock edges.
        mode = 2'd1; expected = 16'hA5C3;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (20) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 chk_reset_outputs("async_rst");
        @(negedge clk) rst_n = 1'b1;
        run_sweep(1, -1);

        run_short(0, 16);
        run_short(3, 64);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
